// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its datapath:
// state encoding, opcode/funct constants and mux/ALU select encodings.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF0 = 3'd0,
    ST_IF1 = 3'd1,
    ST_DCD = 3'd2,
    ST_EXE = 3'd3,
    ST_MEM = 3'd4,
    ST_WB  = 3'd5
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  // ALU operation select
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // Next-PC select
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;

  // Immediate extension select
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Register-file write data select
  localparam logic [1:0] DSEL_PC = 2'b00;
  localparam logic [1:0] DSEL_DL = 2'b01;
  localparam logic [1:0] DSEL_DM = 2'b10;

  // Register-file write address select
  localparam logic [1:0] RSEL_RD = 2'b00;
  localparam logic [1:0] RSEL_RT = 2'b01;
  localparam logic [1:0] RSEL_RA = 2'b10;

  // One-hot instruction class produced by the decoder
  typedef struct packed {
    logic rtype;
    logic ori;
    logic addiu;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master = controller (drives enables/selects), slave = datapath (drives IR fields and zero).
interface mc_ctrl_fsm_if;
  import mc_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr;
  logic [1:0] npcop;
  logic       IRWr;
  logic       RFWr;
  logic [1:0] R_sel;
  logic [1:0] D_sel;
  logic       sel;
  logic [1:0] extop;
  logic [3:0] aluop;
  logic       wren;
  logic       ill;

  modport master (
    input  op, funct, zero,
    output PCWr, npcop, IRWr, RFWr, R_sel, D_sel, sel, extop, aluop, wren, ill
  );

  modport slave (
    output op, funct, zero,
    input  PCWr, npcop, IRWr, RFWr, R_sel, D_sel, sel, extop, aluop, wren, ill
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct decode into a one-hot instruction class plus the ALU
// operation that class uses in EXE. Unknown op or R-type funct flags illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output insn_class_t cls,
  output logic [3:0]  aluop
);

  // Classify the instruction and pick its ALU operation
  always_comb begin
    cls   = '0;
    aluop = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        case (funct)
          FUNCT_ADDU: aluop = ALU_ADD;
          FUNCT_SUBU: aluop = ALU_SUB;
          FUNCT_AND:  aluop = ALU_AND;
          FUNCT_OR:   aluop = ALU_OR;
          FUNCT_SLT:  aluop = ALU_SLT;
          default: begin
            cls.rtype   = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ORI:   begin cls.ori   = 1'b1; aluop = ALU_OR;  end
      OP_ADDIU: begin cls.addiu = 1'b1; aluop = ALU_ADD; end
      OP_LUI:   begin cls.lui   = 1'b1; aluop = ALU_ADD; end
      OP_LW:    begin cls.lw    = 1'b1; aluop = ALU_ADD; end
      OP_SW:    begin cls.sw    = 1'b1; aluop = ALU_ADD; end
      OP_BEQ:   begin cls.beq   = 1'b1; aluop = ALU_SUB; end
      OP_J:     cls.j   = 1'b1;
      OP_JAL:   cls.jal = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the single-bus MIPS datapath.
// Outputs are decoded from the current state, instruction class and zero so
// that beq can commit its branch in the same EXE cycle the ALU compares.
// Reset drops straight to IF0, where every enable is low, so any pending
// PC/RF/DM write of an interrupted instruction is discarded.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master ctrl
);

  state_t      state_r;
  insn_class_t cls_s;
  logic [3:0]  dec_alu_s;

  logic       pcwr_s;
  logic [1:0] npcop_s;
  logic       irwr_s;
  logic       rfwr_s;
  logic [1:0] r_sel_s;
  logic [1:0] d_sel_s;
  logic       sel_s;
  logic [1:0] extop_s;
  logic [3:0] aluop_s;
  logic       wren_s;
  logic       ill_s;

  mc_ctrl_decode u_decode (
    .op    (ctrl.op),
    .funct (ctrl.funct),
    .cls   (cls_s),
    .aluop (dec_alu_s)
  );

  // State sequencing through fetch, decode, execute, memory and write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IF0;
    end else begin
      case (state_r)
        ST_IF0: state_r <= ST_IF1;
        ST_IF1: state_r <= ST_DCD;
        ST_DCD: begin
          if (cls_s.j || cls_s.jal || cls_s.illegal) begin
            state_r <= ST_IF0;
          end else begin
            state_r <= ST_EXE;
          end
        end
        ST_EXE: begin
          if (cls_s.lw || cls_s.sw) begin
            state_r <= ST_MEM;
          end else if (cls_s.beq) begin
            state_r <= ST_IF0;
          end else begin
            state_r <= ST_WB;
          end
        end
        ST_MEM: begin
          if (cls_s.lw) begin
            state_r <= ST_WB;
          end else begin
            state_r <= ST_IF0;
          end
        end
        ST_WB:   state_r <= ST_IF0;
        default: state_r <= ST_IF0;
      endcase
    end
  end

  // Datapath enables and selects for the current state
  always_comb begin
    pcwr_s  = 1'b0;
    npcop_s = NPC_PC4;
    irwr_s  = 1'b0;
    rfwr_s  = 1'b0;
    r_sel_s = RSEL_RD;
    d_sel_s = DSEL_PC;
    sel_s   = 1'b0;
    extop_s = EXT_ZERO;
    aluop_s = ALU_ADD;
    wren_s  = 1'b0;
    ill_s   = 1'b0;
    case (state_r)
      ST_IF0: begin
        irwr_s = 1'b0;
      end
      ST_IF1: begin
        irwr_s  = 1'b1;
        pcwr_s  = 1'b1;
        npcop_s = NPC_PC4;
      end
      ST_DCD: begin
        if (cls_s.j || cls_s.jal) begin
          pcwr_s  = 1'b1;
          npcop_s = NPC_JMP;
          // jal links the already-incremented PC on the same edge as the jump
          rfwr_s  = cls_s.jal;
          r_sel_s = cls_s.jal ? RSEL_RA : RSEL_RD;
          d_sel_s = DSEL_PC;
        end else if (cls_s.illegal) begin
          ill_s = 1'b1;
        end else begin
          ill_s = 1'b0;
        end
      end
      ST_EXE: begin
        aluop_s = dec_alu_s;
        if (cls_s.rtype) begin
          sel_s = 1'b0;
        end else if (cls_s.ori) begin
          sel_s   = 1'b1;
          extop_s = EXT_ZERO;
        end else if (cls_s.lui) begin
          sel_s   = 1'b1;
          extop_s = EXT_LUI;
        end else if (cls_s.addiu || cls_s.lw || cls_s.sw) begin
          sel_s   = 1'b1;
          extop_s = EXT_SIGN;
        end else if (cls_s.beq) begin
          sel_s   = 1'b0;
          pcwr_s  = ctrl.zero;
          npcop_s = NPC_BEQ;
        end else begin
          sel_s = 1'b0;
        end
      end
      ST_MEM: begin
        // Keep the address path stable while DM is accessed
        sel_s   = 1'b1;
        extop_s = EXT_SIGN;
        if (cls_s.sw) begin
          wren_s = 1'b1;
        end else begin
          wren_s = 1'b0;
        end
      end
      ST_WB: begin
        rfwr_s = 1'b1;
        if (cls_s.rtype) begin
          r_sel_s = RSEL_RD;
          d_sel_s = DSEL_DL;
        end else if (cls_s.lw) begin
          r_sel_s = RSEL_RT;
          d_sel_s = DSEL_DM;
        end else if (cls_s.ori || cls_s.addiu || cls_s.lui) begin
          r_sel_s = RSEL_RT;
          d_sel_s = DSEL_DL;
        end else begin
          rfwr_s = 1'b0;
        end
      end
      default: begin
        irwr_s = 1'b0;
      end
    endcase
  end

  assign ctrl.PCWr  = pcwr_s;
  assign ctrl.npcop = npcop_s;
  assign ctrl.IRWr  = irwr_s;
  assign ctrl.RFWr  = rfwr_s;
  assign ctrl.R_sel = r_sel_s;
  assign ctrl.D_sel = d_sel_s;
  assign ctrl.sel   = sel_s;
  assign ctrl.extop = extop_s;
  assign ctrl.aluop = aluop_s;
  assign ctrl.wren  = wren_s;
  assign ctrl.ill   = ill_s;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control words are
// queued when an instruction is presented and popped each cycle for compare.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pcwr;
    logic [1:0] npcop;
    logic       irwr;
    logic       rfwr;
    logic [1:0] r_sel;
    logic [1:0] d_sel;
    logic       sel;
    logic [1:0] extop;
    logic [3:0] aluop;
    logic       wren;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  ctl_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mc_ctrl_fsm_if ctrl_if ();

  mc_ctrl_fsm u_dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl_if)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t c;
    c.pcwr  = ctrl_if.PCWr;
    c.npcop = ctrl_if.npcop;
    c.irwr  = ctrl_if.IRWr;
    c.rfwr  = ctrl_if.RFWr;
    c.r_sel = ctrl_if.R_sel;
    c.d_sel = ctrl_if.D_sel;
    c.sel   = ctrl_if.sel;
    c.extop = ctrl_if.extop;
    c.aluop = ctrl_if.aluop;
    c.wren  = ctrl_if.wren;
    c.ill   = ctrl_if.ill;
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_rtype(input string mn);
    return (mn == "addu" || mn == "subu" || mn == "and" || mn == "or" || mn == "slt");
  endfunction

  function automatic int ncyc(input string mn);
    if (mn == "j" || mn == "jal" || mn == "ill_op" || mn == "ill_fn") return 3;
    else if (mn == "beq") return 4;
    else if (mn == "lw") return 6;
    else return 5;
  endfunction

  // Reference control word for cycle cyc (0 = IF0) of instruction mn
  function automatic ctl_t model(input string mn, input int cyc, input logic z);
    ctl_t c = '0;
    case (cyc)
      0: c = '0;
      1: begin c.irwr = 1'b1; c.pcwr = 1'b1; end
      2: begin
        if (mn == "j" || mn == "jal") begin c.pcwr = 1'b1; c.npcop = 2'b10; end
        if (mn == "jal") begin c.rfwr = 1'b1; c.r_sel = 2'b10; c.d_sel = 2'b00; end
        if (mn == "ill_op" || mn == "ill_fn") c.ill = 1'b1;
      end
      3: begin
        case (mn)
          "addu":  c.aluop = 4'b0000;
          "subu":  c.aluop = 4'b0001;
          "and":   c.aluop = 4'b0010;
          "or":    c.aluop = 4'b0011;
          "slt":   c.aluop = 4'b0100;
          "ori":   begin c.sel = 1'b1; c.extop = 2'b00; c.aluop = 4'b0011; end
          "addiu": begin c.sel = 1'b1; c.extop = 2'b01; end
          "lui":   begin c.sel = 1'b1; c.extop = 2'b10; end
          "lw":    begin c.sel = 1'b1; c.extop = 2'b01; end
          "sw":    begin c.sel = 1'b1; c.extop = 2'b01; end
          "beq":   begin c.aluop = 4'b0001; c.pcwr = z; c.npcop = 2'b01; end
          default: c = '0;
        endcase
      end
      4: begin
        if (mn == "lw" || mn == "sw") begin
          c.sel = 1'b1; c.extop = 2'b01; c.wren = (mn == "sw");
        end else begin
          c.rfwr = 1'b1; c.d_sel = 2'b01;
          c.r_sel = is_rtype(mn) ? 2'b00 : 2'b01;
        end
      end
      5: begin c.rfwr = 1'b1; c.r_sel = 2'b01; c.d_sel = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic set_insn(input string mn);
    ctrl_if.funct = 6'b000000;
    case (mn)
      "addu":   begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b100001; end
      "subu":   begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b100011; end
      "and":    begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b100100; end
      "or":     begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b100101; end
      "slt":    begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b101010; end
      "ill_fn": begin ctrl_if.op = 6'b000000; ctrl_if.funct = 6'b000000; end
      "ori":    ctrl_if.op = 6'b001101;
      "addiu":  ctrl_if.op = 6'b001001;
      "lui":    ctrl_if.op = 6'b001111;
      "lw":     ctrl_if.op = 6'b100011;
      "sw":     ctrl_if.op = 6'b101011;
      "beq":    ctrl_if.op = 6'b000100;
      "j":      ctrl_if.op = 6'b000010;
      "jal":    ctrl_if.op = 6'b000011;
      default:  ctrl_if.op = 6'b111111;
    endcase
  endtask

  // Pop and compare one expected word per cycle; called #1 after a rising edge
  task automatic drain(input string mn);
    ctl_t e;
    int   k;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s_c%0d", mn, k), 32'(observed()), 32'(e));
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_insn(input string mn, input logic z);
    set_insn(mn);
    ctrl_if.zero = z;
    for (int k = 0; k < ncyc(mn); k++) exp_q.push_back(model(mn, k, z));
    drain(mn);
  endtask

  string names[16] = '{"addu", "subu", "and", "or", "slt", "ori", "addiu", "lui",
                       "lw", "sw", "beq", "beq", "j", "jal", "ill_op", "ill_fn"};

  initial begin
    rst = 1'b1;
    ctrl_if.op = 6'b000000;
    ctrl_if.funct = 6'b000000;
    ctrl_if.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_hold", 32'(observed()), 32'(ctl_t'('0)));
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of lw's EXE cycle
    set_insn("lw");
    ctrl_if.zero = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(model("lw", k, 1'b0));
    drain("lw_pre");
    check_eq("lw_exe_pre_rst", 32'(observed()), 32'(model("lw", 3, 1'b0)));
    #2 rst = 1'b1;
    #1 check_eq("rst_async", 32'(observed()), 32'(ctl_t'('0)));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_held%0d", k), 32'(observed()), 32'(ctl_t'('0)));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    // IF0 then IF1 (first IRWr) after release
    run_insn("addu", 1'b0);

    // Every supported instruction plus both illegal forms
    foreach (names[i]) run_insn(names[i], (i == 10) ? 1'b1 : 1'b0);

    // A short random stream with random zero
    for (int r = 0; r < 10; r++) begin
      run_insn(names[$urandom_range(15, 0)], 1'($urandom_range(1, 0)));
    end

    @(negedge clk);
    check_eq("final_if0", 32'(observed()), 32'(ctl_t'('0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control unit for the single-bus MIPS datapath (PC/NPC, synchronous IM, IR, RF, EXT, ALU, DL, synchronous DM). It decodes `op`/`funct` from the IR and, with `zero` from the ALU, sequences every datapath enable and select through fetch, decode, execute, memory and write-back states. No delay slots: `jal` links the already-incremented PC (PC+4).

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equality flag (combinational, this cycle).
- `PCWr`  out  1  PC load enable.
- `npcop`  out  2  00 PC+4, 01 beq target, 10 j/jal target, 11 unused.
- `IRWr`  out  1  IR load enable.
- `RFWr`  out  1  register-file write enable.
- `R_sel`  out  2  write address: 00 rd, 01 rt, 10 $31.
- `D_sel`  out  2  write data: 00 PC, 01 DL, 10 DM.
- `sel`  out  1  ALU B: 0 RF B, 1 Imm32.
- `extop`  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- `aluop`  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT.
- `wren`  out  1  DM write enable.
- `ill`  out  1  one-cycle pulse in DCD for an unsupported op/funct.

## Operation
- Supported ops: R-type (op 000000) addu 100001, subu 100011, and 100100, or 100101, slt 101010; ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: IF0, IF1, DCD, EXE, MEM, WB. Reset state is IF0.
- IF0: IM reads PC. All enables 0. Next state is IF1.
- IF1: IRWr=1, PCWr=1, npcop=00. Next state is DCD.
- DCD: RF reads rs/rt.
  - j: PCWr=1, npcop=10. Next state IF0.
  - jal: as j, plus RFWr=1, R_sel=10, D_sel=00. Next state IF0.
  - illegal: ill=1. Next state IF0, with no write.
  - All others: next state EXE.
- EXE: ALU operates; DL captures the result at the clock edge.
  - R-type: sel=0, aluop from funct. Next state WB.
  - ori: sel=1, extop=00, OR. Next state WB.
  - addiu: sel=1, extop=01, ADD. Next state WB.
  - lui: sel=1, extop=10, ADD. Next state WB.
  - lw/sw: sel=1, extop=01, ADD. Next state MEM.
  - beq: sel=0, SUB; PCWr=zero, npcop=01. Next state IF0.
- MEM: sel=1, extop=01 held stable.
  - lw: DM reads DL. Next state WB.
  - sw: wren=1, DM writes RF B. Next state IF0.
- WB: RFWr=1.
  - R-type: R_sel=00, D_sel=01.
  - ori/addiu/lui: R_sel=01, D_sel=01.
  - lw: R_sel=01, D_sel=10.
  - Next state IF0.
- Outputs not listed for a state are 0. They are combinational from state, op, funct and zero; op and funct are stable from DCD onward because IRWr is asserted only in IF1.

## Timing
- Cycle counts: j/jal 3; beq 4; R-type/ori/addiu/lui 5; sw 5; lw 6.
- Enables take effect at the rising edge that ends the state.
- jal: PC and $31 update on the same edge; $31 receives the pre-jump PC (PC+4).
- Reset: asserting `rst` forces IF0 immediately (asynchronous). In IF0 all enables are 0, including while `rst` is held. This also applies mid-instruction: a pending RF/DM/PC write is dropped.
- The first fetch starts on the first rising edge after `rst` deasserts.
- `ill` is high for exactly the one DCD cycle.
- Unused funct or npcop=11 is never driven.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state encoding;
  - op and funct constants;
  - aluop, npcop, extop, D_sel and R_sel encodings.
  The datapath muxes share the same package.
- Sub-module `mc_ctrl_decode`: combinational op/funct to instruction-class decode (rtype, ori, addiu, lui, lw, sw, beq, j, jal, illegal) plus aluop. The FSM top consumes the class bits.

## Test plan
- Reset mid-EXE of lw → state IF0 at once. RFWr, wren and PCWr stay 0 until release. The first IRWr pulse comes 2 cycles after release.
- addu (op 0, funct 100001) → sequence IF0, IF1, DCD, EXE (aluop 0000, sel 0), WB (RFWr 1, R_sel 00, D_sel 01). Total 5 cycles.
- lw → EXE (sel 1, extop 01, ADD), MEM (wren 0), WB (RFWr 1, R_sel 01, D_sel 10). Total 6 cycles. sw → MEM has wren 1 for one cycle; no RFWr at any point.
- beq: zero=1 → EXE has PCWr 1, npcop 01. zero=0 → EXE has PCWr 0. Either way the next state is IF0 after 4 cycles.
- jal → DCD has PCWr 1, npcop 10, RFWr 1, R_sel 10, D_sel 00, and the next cycle is IF0. j → same but RFWr 0.
- op 111111 → ill pulses for 1 cycle in DCD, all write enables 0, and the next cycle is IF0.
